// File: rtl/conv_patch_generator.sv
`timescale 1ns/1ps
// conv_patch_generator
//
// Turns a raster-order pixel stream into 3x3 sliding-window patches, using
// valid-mode convolution with stride 1. It drives the packed patch bus of the
// downstream Hadamard stage. Two line buffers hold the previous two image rows.
// A 3x3 window register shifts left by one column on every accepted pixel.
// Patch emission depends only on the row/col counters, so stale window or
// line-buffer contents at row or frame starts are never emitted.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_pixel   input pixel, raster order (row-major, column fastest)
//   in_valid   in_pixel is valid
//   in_ready   block can accept a pixel (combinational)
//   patch      packed window; element r*3+c = window row r, column c
//   out_valid  patch is valid
//   out_ready  downstream accepts patch
//   out_last   qualifies the final patch of a frame
module conv_patch_generator #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 9,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             in_pixel,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [SIZE-1:0][WIDTH-1:0]   patch,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   typedef logic [SIZE-1:0][WIDTH-1:0] win_t;

   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   win_t             win_q, win_d;
   win_t             patch_q, patch_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;

   logic [WIDTH-1:0] lb0_q [IMG_W];
   logic [WIDTH-1:0] lb1_q [IMG_W];
   logic [WIDTH-1:0] lb0_rd;
   logic [WIDTH-1:0] lb1_rd;

   logic             in_acc;
   logic             col_end;
   logic             row_end;
   logic             emit;

   // The single output slot may only be refilled when it is empty or
   // is being drained in the same cycle.
   assign in_ready = !rst && (!valid_q || out_ready);
   assign in_acc   = in_valid && in_ready;

   assign col_end  = (col_q == CW'(IMG_W - 1));
   assign row_end  = (row_q == RW'(IMG_H - 1));
   assign emit     = in_acc && (row_q >= RW'(2)) && (col_q >= CW'(2));

   // lb1 holds row-2 and lb0 holds row-1 at the current column.
   assign lb0_rd   = lb0_q[col_q];
   assign lb1_rd   = lb1_q[col_q];

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (in_acc) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Shift left by one column. The new right column holds the oldest row on top.
   always_comb begin
      win_d = win_q;
      if (in_acc) begin
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = lb1_rd;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = lb0_rd;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = in_pixel;
      end
   end

   always_comb begin
      patch_d = patch_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (emit) begin
         patch_d = win_d;
         valid_d = 1'b1;
         last_d  = row_end && col_end;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         win_q   <= '0;
         patch_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         win_q   <= win_d;
         patch_q <= patch_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   // The line buffers have no reset. Their contents only reach the output
   // after being overwritten by fresh pixels of the current frame.
   always_ff @(posedge clk) begin
      if (in_acc) begin
         lb1_q[col_q] <= lb0_rd;
         lb0_q[col_q] <= in_pixel;
      end
   end

   assign patch     = patch_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;

endmodule

// File: tb/tb_conv_patch_generator.sv
`timescale 1ns/1ps
module tb_conv_patch_generator;

   localparam int WIDTH = 32;
   localparam int SIZE  = 9;
   localparam int W     = 8;
   localparam int H     = 8;
   localparam int NPF   = (W - 2) * (H - 2);

   typedef logic [SIZE-1:0][WIDTH-1:0] patch_t;

   logic               clk = 1'b0;
   logic               rst;
   logic [WIDTH-1:0]   in_pixel;
   logic               in_valid;
   logic               in_ready;
   patch_t             patch;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;

   always #5 clk = ~clk;

   conv_patch_generator #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_pixel  (in_pixel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .patch     (patch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   int     n_checks = 0;
   int     n_fail   = 0;

   logic   s_in_ready;
   logic   s_out_valid;
   logic   s_last;
   logic   s_in_acc;
   patch_t s_patch;

   patch_t q_patch[$];
   logic   q_last[$];
   int     n_acc;
   int     first_valid;
   int     pend_idx;
   logic   ov_after[256];

   function automatic patch_t exp_patch(input int k);
      patch_t p;
      int tr, tc;
      tr = k / (W - 2);
      tc = k % (W - 2);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            p[r*3+c] = WIDTH'((tr + r) * W + (tc + c) + 1);
      return p;
   endfunction

   function automatic logic [WIDTH-1:0] pix(input int i);
      return WIDTH'((i % (W * H)) + 1);
   endfunction

   // One clock: drive at the falling edge, sample 1 ns later, then wait for
   // the next falling edge. Output handshakes are logged to the queues.
   task automatic cycle(input logic v, input logic [WIDTH-1:0] px, input logic ordy);
      in_valid  = v;
      in_pixel  = px;
      out_ready = ordy;
      #1;
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_patch     = patch;
      s_last      = out_last;
      s_in_acc    = v && in_ready;
      if (out_valid && ordy) begin
         q_patch.push_back(patch);
         q_last.push_back(out_last);
      end
      if (pend_idx >= 0 && pend_idx < 256) ov_after[pend_idx] = out_valid;
      if (first_valid < 0 && out_valid === 1'b1) first_valid = n_acc;
      pend_idx = s_in_acc ? n_acc : -1;
      if (s_in_acc) n_acc++;
      @(negedge clk);
   endtask

   task automatic clear_log();
      q_patch.delete();
      q_last.delete();
      n_acc       = 0;
      first_valid = -1;
      pend_idx    = -1;
      for (int i = 0; i < 256; i++) ov_after[i] = 1'bx;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle(1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic stream(input int npix);
      for (int i = 0; i < npix; i++) cycle(1'b1, pix(i), 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle(1'b1, 32'h5, 1'b1);
      n_checks++;
      if (s_in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b expected 0", s_in_ready);
      end
      cycle(1'b1, 32'h5, 1'b1);
      n_checks++;
      if (s_out_valid !== 1'b0 || s_last !== 1'b0 || s_patch !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b last=%b patch=%h expected 0/0/0",
                  s_out_valid, s_last, s_patch);
      end
      rst = 1'b0;
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (s_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_in_ready: got %b expected 1", s_in_ready);
      end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] first_c [9] = '{1, 2, 3, 9, 10, 11, 17, 18, 19};
      logic [WIDTH-1:0] last_c  [9] = '{46, 47, 48, 54, 55, 56, 62, 63, 64};
      logic [WIDTH-1:0] row3_c  [9] = '{9, 10, 11, 17, 18, 19, 25, 26, 27};
      int bad;
      do_reset();
      clear_log();
      stream(W * H);

      n_checks++;
      if (first_valid !== 19) begin
         n_fail++;
         $display("FAIL basic_first_valid: got after %0d accepts expected 19", first_valid);
      end
      n_checks++;
      if (q_patch.size() !== NPF) begin
         n_fail++;
         $display("FAIL basic_count: got %0d expected %0d", q_patch.size(), NPF);
      end
      if (q_patch.size() == NPF) begin
         for (int k = 0; k < NPF; k++) begin
            n_checks++;
            if (q_patch[k] !== exp_patch(k) || q_last[k] !== (k == NPF - 1)) begin
               n_fail++;
               $display("FAIL basic_patch[%0d]: got %h last=%b expected %h last=%b",
                        k, q_patch[k], q_last[k], exp_patch(k), (k == NPF - 1));
            end
         end
         bad = 0;
         for (int e = 0; e < 9; e++)
            if (q_patch[0][e] !== first_c[e] || q_patch[NPF-1][e] !== last_c[e] ||
                q_patch[W-2][e] !== row3_c[e]) bad++;
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL basic_hand_patches: got first=%h row3=%h last=%h, %0d elements differ from expected",
                     q_patch[0], q_patch[W-2], q_patch[NPF-1], bad);
         end
      end
      for (int a = 0; a < W * H; a++) begin
         n_checks++;
         if (ov_after[a] !== ((a / W >= 2) && (a % W >= 2))) begin
            n_fail++;
            $display("FAIL row_wrap_gate[acc %0d]: got out_valid=%b expected %b",
                     a, ov_after[a], ((a / W >= 2) && (a % W >= 2)));
         end
      end
   endtask

   task automatic test_backpressure();
      int miss;
      do_reset();
      clear_log();
      for (int i = 0; i < 19; i++) cycle(1'b1, pix(i), 1'b1);
      for (int s = 0; s < 5; s++) begin
         cycle(1'b1, pix(19), 1'b0);
         n_checks++;
         if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 ||
             s_patch !== exp_patch(0) || s_last !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got in_ready=%b valid=%b last=%b patch=%h expected 0/1/0 %h",
                     s, s_in_ready, s_out_valid, s_last, s_patch, exp_patch(0));
         end
      end
      miss = 0;
      for (int i = 19; i < W * H; i++) begin
         cycle(1'b1, pix(i), 1'b1);
         if (s_in_acc !== 1'b1) miss++;
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (miss != 0 || n_acc != W * H) begin
         n_fail++;
         $display("FAIL bp_flow: got %0d stalled cycles, %0d accepts expected 0, %0d",
                  miss, n_acc, W * H);
      end
      n_checks++;
      if (q_patch.size() !== NPF) begin
         n_fail++;
         $display("FAIL bp_count: got %0d expected %0d", q_patch.size(), NPF);
      end
      miss = 0;
      if (q_patch.size() == NPF)
         for (int k = 0; k < NPF; k++)
            if (q_patch[k] !== exp_patch(k) || q_last[k] !== (k == NPF - 1)) miss++;
      n_checks++;
      if (miss != 0) begin
         n_fail++;
         $display("FAIL bp_patches: got %0d wrong patches expected 0", miss);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      clear_log();
      stream(2 * W * H);
      n_checks++;
      if (q_patch.size() !== 2 * NPF) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d expected %0d", q_patch.size(), 2 * NPF);
      end
      if (q_patch.size() == 2 * NPF) begin
         for (int k = 0; k < 2 * NPF; k++) begin
            n_checks++;
            if (q_patch[k] !== exp_patch(k % NPF) || q_last[k] !== ((k % NPF) == NPF - 1)) begin
               n_fail++;
               $display("FAIL b2b_patch[%0d]: got %h last=%b expected %h last=%b",
                        k, q_patch[k], q_last[k], exp_patch(k % NPF), ((k % NPF) == NPF - 1));
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int miss;
      do_reset();
      clear_log();
      for (int i = 0; i < 30; i++) cycle(1'b1, pix(i), 1'b1);
      rst = 1'b1;
      cycle(1'b1, pix(30), 1'b0);
      n_checks++;
      if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_pending: got valid=%b in_ready=%b expected 1/0", s_out_valid, s_in_ready);
      end
      rst = 1'b0;
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (s_out_valid !== 1'b0 || s_last !== 1'b0 || s_patch !== '0 || s_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_after_reset: got valid=%b last=%b patch=%h in_ready=%b expected 0/0/0/1",
                  s_out_valid, s_last, s_patch, s_in_ready);
      end
      clear_log();
      stream(W * H);
      n_checks++;
      if (first_valid !== 2 * W + 3) begin
         n_fail++;
         $display("FAIL mid_first_valid: got after %0d accepts expected %0d", first_valid, 2 * W + 3);
      end
      n_checks++;
      if (q_patch.size() !== NPF) begin
         n_fail++;
         $display("FAIL mid_count: got %0d expected %0d", q_patch.size(), NPF);
      end
      miss = 0;
      if (q_patch.size() == NPF)
         for (int k = 0; k < NPF; k++)
            if (q_patch[k] !== exp_patch(k) || q_last[k] !== (k == NPF - 1)) miss++;
      n_checks++;
      if (miss != 0) begin
         n_fail++;
         $display("FAIL mid_patches: got %0d wrong patches expected 0", miss);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_pixel  = '0;
      out_ready = 1'b0;
      clear_log();
      @(negedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_patch_generator.md
# conv_patch_generator

Streaming 3x3 sliding-window generator that converts a raster-order pixel stream into packed patches for the `hadamard_product_unit` `patch` input. It sits upstream of the Hadamard stage and acts as the producer side of the packed `[SIZE-1:0][WIDTH-1:0]` patch bus. It uses two line buffers and a 3x3 window register. Output is valid-mode convolution with stride 1: one patch per input pixel once the window is full.

## Interface
- `WIDTH`, 32, pixel width in bits.
- `SIZE`, 9, patch element count. Fixed at 9 (3x3); other values are unsupported.
- `IMG_W`, 8, image width in pixels (>= 3).
- `IMG_H`, 8, image height in pixels (>= 3).

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_pixel`  in  WIDTH  input pixel, raster order (row-major, column fastest).
- `in_valid`  in  1  `in_pixel` is valid.
- `in_ready`  out  1  block can accept a pixel.
- `patch`  out  [SIZE-1:0][WIDTH-1:0]  packed window. Element `r*3+c` is window row r, column c; element 0 is top-left.
- `out_valid`  out  1  `patch` is valid.
- `out_ready`  in  1  downstream accepts `patch`.
- `out_last`  out  1  qualifies the final patch of a frame.

## Operation
- Input accept: `in_valid && in_ready`. Output accept: `out_valid && out_ready`.
- `in_ready = !rst && (!out_valid || out_ready)`, combinational. Consequences:
  - The single output slot is never overwritten.
  - Full throughput when `out_ready` is held high.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1):
  - Advance only on input accept.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_H-1, IMG_W-1), both wrap to 0. The next pixel starts a new frame with no gap cycle.
- On each input accept:
  - The window shifts left by one column.
  - The new right column is {linebuf1[col], linebuf0[col], in_pixel}, top to bottom.
  - Writes: linebuf1[col] <= linebuf0[col], linebuf0[col] <= in_pixel.
- Patch emission: an accept at (row, col) with row >= 2 and col >= 2 emits a patch whose top-left pixel is (row-2, col-2).
  - Patches are gated purely by the counters.
  - Stale window/line-buffer data at row or frame starts never reaches the output.
- `out_last` = 1 exactly for the patch whose top-left is (IMG_H-3, IMG_W-3).
- Patches per frame: (IMG_W-2)*(IMG_H-2). With defaults this is 36.
- No arithmetic; data passes through unchanged at WIDTH bits.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - `out_valid`=0, `out_last`=0, `patch`=0.
  - `row`=0, `col`=0; window registers 0.
  - `in_ready`=0 while `rst`=1, and 1 on the first cycle after release.
  - Line-buffer contents are don't-care.
- Latency: a patch-completing input accept in cycle N gives `out_valid`=1 with the corresponding `patch` in cycle N+1.
- Hold: while `out_valid`=1 and `out_ready`=0, `patch`, `out_last` and `out_valid` stay stable and `in_ready`=0.
- Output accept in cycle N with no new patch-completing input: `out_valid`=0 in N+1.
- Simultaneous output accept and patch-completing input accept in cycle N: the new patch appears in N+1 with `out_valid` still 1.
- Reset mid-frame or mid-handshake:
  - A pending patch is dropped.
  - Counters restart at (0,0).
  - The first patch after reset needs 2*IMG_W+3 fresh pixels.
- `in_valid` may toggle arbitrarily. Bubbles do not advance counters or the window.

## Test plan
- Basic: stream an 8x8 frame with pixel(r,c) = r*8+c+1, `out_ready`=1, `in_valid`=1.
  - First `out_valid` one cycle after the 19th accept.
  - `patch` = {1,2,3,9,10,11,17,18,19} for elements 0..8.
  - Exactly 36 patches.
- Frame end: on the same stream, the last patch is {46,47,48,54,55,56,62,63,64} with `out_last`=1. `out_last`=0 on all other patches.
- Backpressure: hold `out_ready`=0 for 5 cycles while the first patch is pending.
  - `in_ready`=0 and `patch` is unchanged throughout.
  - Raising `out_ready` restores one-pixel-per-cycle flow.
  - All 36 patches match the basic run.
- Row wrap: check no patch is emitted for accepts at col 0 or 1 of any row. The first patch of row 3 is {9,10,11,17,18,19,25,26,27}.
- Back-to-back frames: send two identical frames with no gap.
  - 72 patches total; the second frame's sequence is identical to the first.
  - `out_last` on patches 36 and 72.
- Reset mid-frame: assert `rst` for 1 cycle after 30 accepts.
  - `out_valid`=0 the following cycle.
  - Replaying a full frame yields the basic-run sequence exactly.
